// File: rtl/alu_stream_unit.sv
// Handshaked 4-bit signed ALU with a 2-entry in-order result buffer.
// Build option ALU_STREAM_SATURATE_EN clamps ADD/SUB overflow results.
module alu_stream_unit #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_in1,
  input  logic [WIDTH-1:0] alu_in2,
  input  logic [1:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             error,
  output logic [CNT_W-1:0] err_count,
  output logic             busy
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] head_res;
  logic [WIDTH-1:0] tail_res;
  logic             head_err;
  logic             tail_err;

  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] res;
  logic             err;
  logic             sa;
  logic             sb;
  logic             accept;
  logic             pop;

  assign add_res = alu_in1 + alu_in2;
  assign sub_res = alu_in1 - alu_in2;
  assign sa      = alu_in1[WIDTH-1];
  assign sb      = alu_in2[WIDTH-1];

  always_comb begin
    res = '0;
    err = 1'b0;
    unique case (opcode)
      2'b00: begin
        res = add_res;
        err = (sa == sb) && (add_res[WIDTH-1] != sa);
      end
      2'b01: begin
        res = sub_res;
        err = (sa != sb) && (sub_res[WIDTH-1] != sa);
      end
      2'b10: res = ~(alu_in1 & alu_in2);
      2'b11: res = alu_in1 ^ alu_in2;
      default: res = '0;
    endcase
`ifdef ALU_STREAM_SATURATE_EN
    // On overflow the true result lies on the side of operand A's sign.
    if (err)
      res = sa ? {1'b1, {(WIDTH-1){1'b0}}}
               : {1'b0, {(WIDTH-1){1'b1}}};
`else
`endif
  end

  assign in_ready  = (state != S_TWO);
  assign out_valid = (state != S_EMPTY);
  assign busy      = out_valid;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign alu_out   = head_res;
  assign error     = head_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_EMPTY;
      head_res <= '0;
      head_err <= 1'b0;
      tail_res <= '0;
      tail_err <= 1'b0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            head_res <= res;
            head_err <= err;
            state    <= S_ONE;
          end
        end
        S_ONE: begin
          if (accept && pop) begin
            head_res <= res;
            head_err <= err;
          end else if (accept) begin
            tail_res <= res;
            tail_err <= err;
            state    <= S_TWO;
          end else if (pop) begin
            state <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (pop) begin
            head_res <= tail_res;
            head_err <= tail_err;
            state    <= S_ONE;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      err_count <= '0;
    else if (accept && err && (err_count != {CNT_W{1'b1}}))
      err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_alu_stream_unit.sv
// Directed self-checking bench for alu_stream_unit.
// Expectations follow ALU_STREAM_SATURATE_EN when it is defined.
module tb_alu_stream_unit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] alu_in1;
  logic [3:0] alu_in2;
  logic [1:0] opcode;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] alu_out;
  logic       error;
  logic [7:0] err_count;
  logic       busy;

  int checks;
  int errors;

  alu_stream_unit #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .alu_in1(alu_in1),
    .alu_in2(alu_in2),
    .opcode(opcode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu_out(alu_out),
    .error(error),
    .err_count(err_count),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one op with out_ready=1; result is at the head one cycle later
  task automatic op1(input logic [1:0] op, input logic [3:0] a,
                     input logic [3:0] b, input logic [3:0] res,
                     input logic e, input logic [7:0] cnt,
                     input string tag);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    opcode    = op;
    alu_in1   = a;
    alu_in2   = b;
    tick();
    in_valid  = 1'b0;
    chk({tag, "_v"}, 32'(out_valid), 32'd1);
    chk({tag, "_res"}, 32'(alu_out), 32'(res));
    chk({tag, "_err"}, 32'(error), 32'(e));
    chk({tag, "_cnt"}, 32'(err_count), 32'(cnt));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    tick();
    tick();
  endtask

  logic [3:0] ovf_add;
  logic [3:0] ovf_sub;

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_in1   = '0;
    alu_in2   = '0;
    opcode    = '0;
`ifdef ALU_STREAM_SATURATE_EN
    ovf_add = 4'h7;
    ovf_sub = 4'h8;
`else
    ovf_add = 4'h8;
    ovf_sub = 4'h7;
`endif
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_ir", 32'(in_ready), 32'd1);
    chk("rst_out", 32'(alu_out), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    chk("rst_cnt", 32'(err_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    op1(2'b00, 4'd3, 4'd4, 4'd7, 1'b0, 8'd0, "add34");
    op1(2'b00, 4'd7, 4'd1, ovf_add, 1'b1, 8'd1, "add71");
    op1(2'b01, 4'h8, 4'd1, ovf_sub, 1'b1, 8'd2, "sub81");
    op1(2'b01, 4'hD, 4'hD, 4'd0, 1'b0, 8'd2, "subm3");
    op1(2'b10, 4'hA, 4'h6, 4'hD, 1'b0, 8'd2, "nand");
    op1(2'b11, 4'hA, 4'h6, 4'hC, 1'b0, 8'd2, "xor");
    out_ready = 1'b1;
    tick();
    chk("idle_ov", 32'(out_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_cnt", 32'(err_count), 32'd2);

    // backpressure: three adds against a stalled consumer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    opcode    = 2'b00;
    alu_in1   = 4'd1;
    alu_in2   = 4'd1;
    tick();
    chk("bp1_ir", 32'(in_ready), 32'd1);
    alu_in1 = 4'd2;
    alu_in2 = 4'd2;
    tick();
    chk("bp2_ir", 32'(in_ready), 32'd0);
    chk("bp2_out", 32'(alu_out), 32'd2);
    alu_in1 = 4'd3;
    alu_in2 = 4'd3;
    tick();
    chk("bp3_ir", 32'(in_ready), 32'd0);
    chk("bp3_hold", 32'(alu_out), 32'd2);
    chk("bp3_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp4_out", 32'(alu_out), 32'd4);
    chk("bp4_ir", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp5_out", 32'(alu_out), 32'd6);
    chk("bp5_ov", 32'(out_valid), 32'd1);
    tick();
    chk("bp6_ov", 32'(out_valid), 32'd0);

    // push count to 5, then fill the buffer and reset
    op1(2'b00, 4'd7, 4'd1, ovf_add, 1'b1, 8'd3, "c3");
    op1(2'b00, 4'd7, 4'd1, ovf_add, 1'b1, 8'd4, "c4");
    op1(2'b00, 4'd7, 4'd1, ovf_add, 1'b1, 8'd5, "c5");
    drain();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    opcode    = 2'b00;
    alu_in1   = 4'd1;
    alu_in2   = 4'd2;
    tick();
    tick();
    chk("full_ir", 32'(in_ready), 32'd0);
    chk("full_cnt", 32'(err_count), 32'd5);
    rst     = 1'b1;
    opcode  = 2'b00;
    alu_in1 = 4'd7;
    alu_in2 = 4'd1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("mrst_ov", 32'(out_valid), 32'd0);
    chk("mrst_ir", 32'(in_ready), 32'd1);
    chk("mrst_cnt", 32'(err_count), 32'd0);
    tick();
    chk("mrst_noacc", 32'(out_valid), 32'd0);
    op1(2'b11, 4'hF, 4'h1, 4'hE, 1'b0, 8'd0, "xor_rst");
    drain();

    // saturation of the overflow counter
    out_ready = 1'b1;
    in_valid  = 1'b1;
    opcode    = 2'b01;
    alu_in1   = 4'h8;
    alu_in2   = 4'd1;
    for (int i = 0; i < 254; i++) tick();
    chk("sat254", 32'(err_count), 32'd254);
    tick();
    chk("sat255", 32'(err_count), 32'd255);
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0;
    chk("sat_hold", 32'(err_count), 32'd255);
    chk("sat_res", 32'(alu_out), 32'(ovf_sub));
    drain();
    chk("sat_pop", 32'(err_count), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_stream_unit.md
Name: alu_stream_unit

Overview:
- Registered, handshaked execution wrapper for the 4-bit signed ALU.
- Accepts operand/opcode transactions over valid/ready, computes ADD/SUB/NAND/XOR with overflow flag, and returns results in order over valid/ready through a 2-entry output buffer.
- Sits between the decode stage (initiator) and writeback (consumer).
- Also keeps a saturating count of overflowed operations for debug readback.

Parameters:
- WIDTH, 4, operand/result width in bits, two's complement.
- CNT_W, 8, width of the error counter.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  initiator presents a transaction
- in_ready  output  1  block can accept a transaction this cycle
- alu_in1  input  WIDTH  signed operand A
- alu_in2  input  WIDTH  signed operand B
- opcode  input  2  00 ADD, 01 SUB (A-B), 10 NAND, 11 XOR
- out_valid  output  1  result entry at buffer head is valid
- out_ready  input  1  consumer takes head entry this cycle
- alu_out  output  WIDTH  result at head
- error  output  1  overflow flag of head entry
- err_count  output  CNT_W  saturating count of accepted ops with error=1
- busy  output  1  buffer non-empty (out_valid mirror, for stall logic)

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous, active-high, and sampled only on the rising edge of `clk`.
- Handshakes:
  - Accept when in_valid && in_ready.
  - Pop when out_valid && out_ready.
- Result computation: computed combinationally from the accepted inputs and written into the buffer at that same edge.
  - Latency is 1 cycle: op accepted at edge N is visible at the head at N+1, if the buffer was empty.
- Arithmetic: result is the low WIDTH bits of the true sum/difference (wraps).
- Error rules:
  - ADD: error=1 iff sign(A)==sign(B) and sign(result)!=sign(A).
  - SUB: error=1 iff sign(A)!=sign(B) and sign(result)!=sign(A).
  - NAND and XOR: error=0.
- Buffer FSM (2 entries, FIFO order, states EMPTY/ONE/TWO):
  - EMPTY: in_ready=1, out_valid=0. Accept -> ONE.
  - ONE: in_ready=1, out_valid=1.
    - Accept & pop -> ONE (new entry becomes head next cycle).
    - Accept only -> TWO.
    - Pop only -> EMPTY.
  - TWO: in_ready=0, out_valid=1. Pop -> ONE; no accept is possible.
- in_ready depends only on state, never combinationally on out_ready.
- Output stability: while out_valid && !out_ready, alu_out/error hold stable.
- err_count:
  - Increments by 1 at the accepting edge of each op whose error=1.
  - Saturates at 2^CNT_W-1; no wrap.
  - Not cleared by pop.
- Invalid cycles: in_valid=0 causes no state change; input values are don't-care.
- Reset values: state EMPTY, out_valid=0, in_ready=1 (from the first cycle after reset), alu_out=0, error=0, err_count=0, busy=0.
- Reset mid-operation: buffered entries are discarded, with no partial pop. A transaction presented in the reset cycle is not accepted.

Optional Feature:
- Macro ALU_STREAM_SATURATE_EN.
- Defined: on ADD/SUB overflow, alu_out is clamped to the signed limit in the direction of the true result (+7 or -8 for WIDTH=4); error still =1 and err_count still increments.
- Undefined: wrapped result as specified above.
- NAND/XOR are unaffected either way.

Test Plan:
- ADD 3+4, out_ready=1 -> alu_out=7, error=0 one cycle after accept; err_count=0.
- ADD 7+1 -> alu_out=-8 (4'b1000), error=1, err_count=1. With ALU_STREAM_SATURATE_EN: alu_out=7, error=1.
- SUB -8-1 -> alu_out=7, error=1 (saturate build: -8). SUB -3-(-3) -> 0, error=0.
- NAND 4'b1010,4'b0110 -> 4'b1101, error=0. XOR same operands -> 4'b1100, error=0.
- Backpressure: out_ready=0, present ops ADD 1+1, ADD 2+2, ADD 3+3 back-to-back:
  - First two accepted, in_ready=0 from third cycle; third op held by initiator.
  - Then raise out_ready -> outputs 2, 4, 6 in order, with the third op accepted after the first pop.
- Reset mid-stream: buffer in TWO with err_count=5, assert rst one cycle -> next cycle out_valid=0, in_ready=1, err_count=0; a subsequent XOR 4'b1111,4'b0001 returns 4'b1110.
